// File: rtl/conv_pkg.sv
// Shared types and parameter derivations for the convolution window scheduler.
//   state_t  : scheduler FSM state encoding
//   CNT_W    : width of every scheduler counter and address output
//   out_dim  : output-pixel grid width/height for a given image and kernel
//   band     : bytes held in one band buffer (KERNEL_DIM image rows, all channels)
package conv_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int unsigned out_dim(input int unsigned img_dim,
                                          input int unsigned kernel_dim);
    return img_dim / kernel_dim;
  endfunction

  function automatic int unsigned band(input int unsigned kernel_dim,
                                       input int unsigned img_dim,
                                       input int unsigned img_ch);
    return kernel_dim * img_dim * img_ch;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Up-counter that advances on enable and wraps to zero after reaching target.
//   clk, rst : clock and asynchronous active-low reset
//   enable   : advance by one this cycle
//   target   : last value before wrapping back to zero
//   count    : current count (registered)
module wrap_counter
  import conv_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [W-1:0] target,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == target) ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/conv_scheduler.sv
// Convolution window scheduler: fills a band buffer with KERNEL_DIM image rows,
// then issues one window per output column, repeating for every output row.
//   clk, rst            : clock and asynchronous active-low reset
//   start               : begin a frame (only honoured in IDLE)
//   in_valid / in_ready : input byte stream handshake
//   wr_en / wr_addr     : band-buffer write strobe and address
//   win_valid/win_ready : window handshake toward the datapath
//   win_base            : band-buffer base address of the current window
//   out_row, out_col    : output-pixel coordinates of the current window
//   busy                : frame in progress
//   frame_done          : one-cycle pulse when the frame finishes
module conv_scheduler
  import conv_pkg::*;
#(
  parameter int unsigned KERNEL_DIM = 2,
  parameter int unsigned IMG_DIM    = 4,
  parameter int unsigned IMG_CH     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic       win_valid,
  input  logic       win_ready,
  output logic [7:0] win_base,
  output logic [7:0] out_row,
  output logic [7:0] out_col,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned OUT_DIM  = out_dim(IMG_DIM, KERNEL_DIM);
  localparam int unsigned BAND     = band(KERNEL_DIM, IMG_DIM, IMG_CH);
  localparam int unsigned WIN_STEP = KERNEL_DIM * IMG_CH;

  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(BAND - 1);
  localparam logic [CNT_W-1:0] OUT_LAST  = CNT_W'(OUT_DIM - 1);

  // Reject geometries the 8-bit band addressing cannot cover.
  generate
    if (BAND > 256 || (IMG_DIM % KERNEL_DIM) != 0) begin : g_bad_geometry
      $error("conv_scheduler: BAND must be <= 256 and IMG_DIM a multiple of KERNEL_DIM");
    end
  endgenerate

  state_t state, state_next;

  logic [CNT_W-1:0] fill_cnt, row_cnt, col_cnt;
  logic             col_last;

  assign col_last = (col_cnt == OUT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state and state-decoded handshake/status outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    win_valid  = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = FILL;
      end
      FILL: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid && fill_cnt == FILL_LAST) state_next = COMPUTE;
      end
      COMPUTE: begin
        busy      = 1'b1;
        win_valid = 1'b1;
        if (win_ready && col_last) state_next = (row_cnt == OUT_LAST) ? DONE : FILL;
      end
      DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr_en = in_valid & in_ready;

  // Counters only ever leave zero mid-frame and wrap back to zero by frame end,
  // so IDLE always starts a frame at address 0, row 0, column 0.
  wrap_counter #(.W(CNT_W)) u_fill_cnt (
    .clk    (clk),
    .rst    (rst),
    .enable (wr_en),
    .target (FILL_LAST),
    .count  (fill_cnt)
  );

  wrap_counter #(.W(CNT_W)) u_col_cnt (
    .clk    (clk),
    .rst    (rst),
    .enable (win_valid & win_ready),
    .target (OUT_LAST),
    .count  (col_cnt)
  );

  wrap_counter #(.W(CNT_W)) u_row_cnt (
    .clk    (clk),
    .rst    (rst),
    .enable (win_valid & win_ready & col_last),
    .target (OUT_LAST),
    .count  (row_cnt)
  );

  assign wr_addr  = fill_cnt;
  assign out_row  = row_cnt;
  assign out_col  = col_cnt;
  assign win_base = CNT_W'(32'(col_cnt) * WIN_STEP);

endmodule

// File: tb/tb_conv_scheduler.sv
// Self-checking bench for conv_scheduler at default geometry (BAND=24, OUT_DIM=2).
module tb_conv_scheduler;

  localparam int K       = 2;
  localparam int IMG     = 4;
  localparam int CH      = 3;
  localparam int OD      = IMG / K;
  localparam int BAND    = K * IMG * CH;
  localparam int NWIN    = OD * OD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       win_ready = 1'b0;
  logic       in_ready, wr_en, win_valid, busy, frame_done;
  logic [7:0] wr_addr, win_base, out_row, out_col;

  conv_scheduler #(.KERNEL_DIM(K), .IMG_DIM(IMG), .IMG_CH(CH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_base   (win_base),
    .out_row    (out_row),
    .out_col    (out_col),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Frame progress model: a frame is just a count of accepted bytes and of
  // issued windows; every output follows arithmetically from those counts.
  bit m_active;
  int m_nw;
  int m_nwin;

  typedef enum int {P_IDLE, P_FILL, P_COMP, P_DONE} phase_t;

  function automatic phase_t phase();
    if (!m_active)                           return P_IDLE;
    if (m_nwin == NWIN)                      return P_DONE;
    if (m_nw == BAND * (m_nwin / OD + 1))    return P_COMP;
    return P_FILL;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 1'b0;
      m_nw     = 0;
      m_nwin   = 0;
    end else begin
      case (phase())
        P_IDLE: if (start) begin m_active = 1'b1; m_nw = 0; m_nwin = 0; end
        P_FILL: if (in_valid) m_nw++;
        P_COMP: if (win_ready) m_nwin++;
        P_DONE: m_active = 1'b0;
        default: ;
      endcase
    end
  end

  // Observed traffic, recorded mid-cycle for the directed literal checks.
  int n_wr, n_win, n_done;
  int addr_q[$];
  int base_q[$];
  int row_q[$];
  int col_q[$];

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    phase_t p;
    int col;
    p   = phase();
    col = m_nwin % OD;
    chk("in_ready",   int'(in_ready),   int'(p == P_FILL));
    chk("wr_en",      int'(wr_en),      int'(p == P_FILL && in_valid));
    chk("wr_addr",    int'(wr_addr),    m_nw % BAND);
    chk("win_valid",  int'(win_valid),  int'(p == P_COMP));
    chk("win_base",   int'(win_base),   col * K * CH);
    chk("out_row",    int'(out_row),    (m_nwin / OD) % OD);
    chk("out_col",    int'(out_col),    col);
    chk("busy",       int'(busy),       int'(m_active));
    chk("frame_done", int'(frame_done), int'(p == P_DONE));
    if (wr_en) begin n_wr++; addr_q.push_back(int'(wr_addr)); end
    if (win_valid && win_ready) begin
      n_win++;
      base_q.push_back(int'(win_base));
      row_q.push_back(int'(out_row));
      col_q.push_back(int'(out_col));
    end
    if (frame_done) n_done++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    n_wr = 0; n_win = 0; n_done = 0;
    addr_q.delete(); base_q.delete(); row_q.delete(); col_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic run_until_done(input string name, input int budget);
    int i;
    i = 0;
    while (!frame_done && i < budget) begin cyc(); i++; end
    if (!frame_done) chk({name, "_done_timeout"}, 0, 1);
    cyc();
  endtask

  initial begin
    int n;

    // Reset state
    cyc(); cyc();
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_win_valid", int'(win_valid), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    rst = 1'b1;
    cyc();

    // Continuous stream, datapath always ready
    clear_rec();
    in_valid = 1'b1; win_ready = 1'b1;
    pulse_start();
    n = 0;
    while (!win_valid && n < 100) begin cyc(); n++; end
    chk("t1_first_win_latency", n, 24);
    run_until_done("t1", 200);
    chk("t1_writes", n_wr, 48);
    chk("t1_windows", n_win, 4);
    chk("t1_frame_done_pulses", n_done, 1);
    chk("t1_base_count", base_q.size(), 4);
    if (base_q.size() == 4) begin
      chk("t1_base0", base_q[0], 0); chk("t1_base1", base_q[1], 6);
      chk("t1_base2", base_q[2], 0); chk("t1_base3", base_q[3], 6);
      chk("t1_row1", row_q[1], 0);   chk("t1_row2", row_q[2], 1);
      chk("t1_col3", col_q[3], 1);
    end
    if (addr_q.size() == 48) begin
      for (int i = 0; i < 48; i++) chk("t1_addr_seq", addr_q[i], i % 24);
    end
    chk("t1_idle_after", int'(busy), 0);

    // Toggling input valid
    clear_rec();
    win_ready = 1'b1;
    in_valid  = 1'b0;
    pulse_start();
    n = 0;
    while (!frame_done && n < 400) begin in_valid = ~in_valid; cyc(); n++; end
    if (!frame_done) chk("t2_done_timeout", 0, 1);
    cyc();
    chk("t2_writes", n_wr, 48);
    chk("t2_windows", n_win, 4);

    // Datapath stall at the first window
    clear_rec();
    in_valid = 1'b1; win_ready = 1'b0;
    pulse_start();
    n = 0;
    while (!win_valid && n < 100) begin cyc(); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_win_valid", int'(win_valid), 1);
      chk("t3_stall_win_base", int'(win_base), 0);
      chk("t3_stall_out_col", int'(out_col), 0);
      chk("t3_stall_in_ready", int'(in_ready), 0);
      cyc();
    end
    win_ready = 1'b1;
    run_until_done("t3", 200);
    chk("t3_windows", n_win, 4);

    // Reset while computing row 1
    clear_rec();
    in_valid = 1'b1; win_ready = 1'b1;
    pulse_start();
    n = 0;
    while (!(win_valid && out_row == 8'd1) && n < 200) begin cyc(); n++; end
    chk("t4_reached_row1", int'(win_valid && out_row == 8'd1), 1);
    win_ready = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    chk("t4_rst_busy", int'(busy), 0);
    chk("t4_rst_win_valid", int'(win_valid), 0);
    chk("t4_rst_out_row", int'(out_row), 0);
    chk("t4_rst_wr_en", int'(wr_en), 0);
    chk("t4_rst_in_ready", int'(in_ready), 0);
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    win_ready = 1'b1;
    pulse_start();
    chk("t4_restart_wr_addr", int'(wr_addr), 0);
    chk("t4_restart_out_row", int'(out_row), 0);
    chk("t4_restart_busy", int'(busy), 1);
    run_until_done("t4", 200);

    // Stray start in FILL and stray valid in IDLE
    in_valid = 1'b1; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5_idle_wr_en", int'(wr_en), 0);
      chk("t5_idle_busy", int'(busy), 0);
    end
    pulse_start();
    for (int i = 0; i < 5; i++) cyc();
    in_valid = 1'b0;
    pulse_start();
    chk("t5_fill_wr_addr", int'(wr_addr), 5);
    chk("t5_fill_busy", int'(busy), 1);
    chk("t5_fill_in_ready", int'(in_ready), 1);
    in_valid = 1'b1;
    run_until_done("t5", 200);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
